// File: rtl/core_pkg.sv
// core_pkg: types and constants shared by the memory responder slice.
//   rd_state_e : data-read FSM state encoding (IDLE, WAIT, RESP)
//   BE_*       : low-aligned byte-lane masks for byte, halfword and word accesses
//   lane_mask  : helper that places a low-aligned lane mask at a byte offset
package core_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } rd_state_e;

  localparam logic [3:0] BE_BYTE = 4'b0001;
  localparam logic [3:0] BE_HALF = 4'b0011;
  localparam logic [3:0] BE_WORD = 4'b1111;

  // Lanes that shift past bit 3 are dropped; those accesses are flagged
  // as misaligned elsewhere and never written.
  function automatic logic [3:0] lane_mask(input logic [3:0] be, input logic [1:0] off);
    return be << off;
  endfunction

endpackage

// File: rtl/mem_lane_align.sv
// mem_lane_align: byte-lane shifter plus misalignment check for one access.
// Used once on the store path (shift data up to its lanes) and once on the
// read path (shift the addressed bytes down to bit 0, zero-filled).
//   be_i         : low-aligned lane mask of the access
//   offset_i     : byte offset within the word (address bits [1:0])
//   data_i       : data to be shifted
//   data_o       : data_i shifted left (SHIFT_LEFT=1) or right by 8*offset_i
//   misaligned_o : halfword at offset 3, or word at a non-zero offset
module mem_lane_align import core_pkg::*; #(
  parameter bit SHIFT_LEFT = 1'b1
) (
  input  logic [3:0]  be_i,
  input  logic [1:0]  offset_i,
  input  logic [31:0] data_i,
  output logic [31:0] data_o,
  output logic        misaligned_o
);

  logic [4:0] shamt;

  assign shamt        = {offset_i, 3'b000};
  assign data_o       = SHIFT_LEFT ? (data_i << shamt) : (data_i >> shamt);
  assign misaligned_o = ((be_i == BE_HALF) && (offset_i == 2'd3)) ||
                        ((be_i == BE_WORD) && (offset_i != 2'd0));

endmodule

// File: rtl/mem_responder.sv
// mem_responder: word-organised memory with a combinational instruction
// fetch port, a byte-lane store port and a wait-stated data-read port.
//   clk, rst           : clock, synchronous active-high reset
//   clk_en             : global advance enable; nothing changes while low
//   i_read_fetch_addr  : instruction word index  -> o_read_fetch_data (comb.)
//   i_read_req/addr    : data-read request and byte address
//   o_read_data/ready  : right-aligned read data, one-cycle completion strobe
//   i_write_enable     : store request, with i_write_addr/i_write_data
//   i_byte_enable      : low-aligned lane mask shared by store and read
//   o_misaligned       : sticky misaligned-access flag (cleared by reset only)
//   o_dbg_state        : current read FSM state
//
// Read handshake: i_read_req is sampled on clk_en cycles while the FSM is
// IDLE; the address and lane mask are captured at that edge. o_read_ready
// is high for exactly one clk_en cycle with o_read_data valid alongside it.
// A request still high in the cycle that o_read_ready is high is accepted
// as a new transaction. Stores have no handshake and never stall.
module mem_responder import core_pkg::*; #(
  parameter int ADDR_WIDTH  = 31,
  parameter int DATA_WIDTH  = 31,
  parameter int DEPTH_WORDS = 1024,
  parameter int WAIT_STATES = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  clk_en,
  input  logic [ADDR_WIDTH:0]   i_read_fetch_addr,
  output logic [DATA_WIDTH:0]   o_read_fetch_data,
  input  logic                  i_read_req,
  input  logic [ADDR_WIDTH:0]   i_read_addr,
  output logic [DATA_WIDTH:0]   o_read_data,
  output logic                  o_read_ready,
  input  logic                  i_write_enable,
  input  logic [3:0]            i_byte_enable,
  input  logic [ADDR_WIDTH:0]   i_write_addr,
  input  logic [DATA_WIDTH:0]   i_write_data,
  output logic                  o_misaligned,
  output rd_state_e             o_dbg_state
);

  localparam int AW    = ADDR_WIDTH + 1;
  localparam int IDX_W = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
  // WAIT lasts WAIT_STATES cycles: the counter counts down to 0 inclusive.
  localparam logic [3:0] WAIT_INIT = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

  function automatic logic [IDX_W-1:0] word_idx(input logic [AW-1:0] a);
    return IDX_W'((a >> 2) % AW'(DEPTH_WORDS));
  endfunction

  logic [31:0] mem_q [DEPTH_WORDS];

  // ---------------- store path ----------------
  logic [IDX_W-1:0] wr_idx;
  logic [1:0]       wr_off;
  logic [3:0]       wr_mask;
  logic [31:0]      wr_data_sh;
  logic             wr_mis;
  logic             wr_go;

  assign wr_idx  = word_idx(i_write_addr);
  assign wr_off  = i_write_addr[1:0];
  assign wr_mask = lane_mask(i_byte_enable, wr_off);
  assign wr_go   = i_write_enable && !wr_mis;

  mem_lane_align #(.SHIFT_LEFT(1'b1)) u_wr_align (
    .be_i         (i_byte_enable),
    .offset_i     (wr_off),
    .data_i       (i_write_data),
    .data_o       (wr_data_sh),
    .misaligned_o (wr_mis)
  );

  always_ff @(posedge clk) begin
    if (clk_en && !rst && wr_go) begin
      for (int l = 0; l < 4; l++) begin
        if (wr_mask[l]) mem_q[wr_idx][8*l +: 8] <= wr_data_sh[8*l +: 8];
      end
    end
  end

  // ---------------- fetch path ----------------
  assign o_read_fetch_data = mem_q[IDX_W'(i_read_fetch_addr % AW'(DEPTH_WORDS))];

  // ---------------- data-read path ----------------
  rd_state_e        state_q;
  logic [3:0]       cnt_q;
  logic [IDX_W-1:0] rd_idx_q;
  logic [1:0]       rd_off_q;
  logic [3:0]       rd_be_q;
  logic             ready_q;
  logic [31:0]      rdata_q;
  logic             mis_q;

  logic [31:0]      rd_word_d;
  logic [31:0]      rd_data_sh;
  logic             rd_mis;

  // The response is sampled on the same edge a store lands, so a store to
  // the captured word in that cycle is merged in ahead of the array.
  always_comb begin
    rd_word_d = mem_q[rd_idx_q];
    if (wr_go && (wr_idx == rd_idx_q)) begin
      for (int l = 0; l < 4; l++) begin
        if (wr_mask[l]) rd_word_d[8*l +: 8] = wr_data_sh[8*l +: 8];
      end
    end
  end

  mem_lane_align #(.SHIFT_LEFT(1'b0)) u_rd_align (
    .be_i         (rd_be_q),
    .offset_i     (rd_off_q),
    .data_i       (rd_word_d),
    .data_o       (rd_data_sh),
    .misaligned_o (rd_mis)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= 4'd0;
      ready_q <= 1'b0;
      rdata_q <= 32'd0;
      mis_q   <= 1'b0;
    end else if (clk_en) begin
      ready_q <= 1'b0;
      if (i_write_enable && wr_mis) mis_q <= 1'b1;
      case (state_q)
        ST_IDLE: begin
          if (i_read_req) begin
            rd_idx_q <= word_idx(i_read_addr);
            rd_off_q <= i_read_addr[1:0];
            rd_be_q  <= i_byte_enable;
            if (WAIT_STATES == 0) begin
              state_q <= ST_RESP;
            end else begin
              state_q <= ST_WAIT;
              cnt_q   <= WAIT_INIT;
            end
          end
        end
        ST_WAIT: begin
          if (cnt_q == 4'd0) state_q <= ST_RESP;
          else               cnt_q   <= cnt_q - 4'd1;
        end
        ST_RESP: begin
          ready_q <= 1'b1;
          rdata_q <= rd_mis ? 32'd0 : rd_data_sh;
          if (rd_mis) mis_q <= 1'b1;
          state_q <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign o_read_ready = ready_q;
  assign o_read_data  = rdata_q;
  assign o_misaligned = mis_q;
  assign o_dbg_state  = state_q;

endmodule

// File: tb/tb_mem_responder.sv
module tb_mem_responder;
  import core_pkg::*;

  localparam int WS    = 3;
  localparam int DEPTH = 64;

  logic        clk;
  logic        rst;
  logic        clk_en;
  logic [31:0] i_read_fetch_addr;
  logic [31:0] o_read_fetch_data;
  logic        i_read_req;
  logic [31:0] i_read_addr;
  logic [31:0] o_read_data;
  logic        o_read_ready;
  logic        i_write_enable;
  logic [3:0]  i_byte_enable;
  logic [31:0] i_write_addr;
  logic [31:0] i_write_data;
  logic        o_misaligned;
  rd_state_e   o_dbg_state;

  mem_responder #(
    .ADDR_WIDTH(31), .DATA_WIDTH(31), .DEPTH_WORDS(DEPTH), .WAIT_STATES(WS)
  ) dut (
    .clk(clk), .rst(rst), .clk_en(clk_en),
    .i_read_fetch_addr(i_read_fetch_addr), .o_read_fetch_data(o_read_fetch_data),
    .i_read_req(i_read_req), .i_read_addr(i_read_addr),
    .o_read_data(o_read_data), .o_read_ready(o_read_ready),
    .i_write_enable(i_write_enable), .i_byte_enable(i_byte_enable),
    .i_write_addr(i_write_addr), .i_write_data(i_write_data),
    .o_misaligned(o_misaligned), .o_dbg_state(o_dbg_state)
  );

  // ---------------- clock / watchdog ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish, observed running expected done");
    $fatal(1, "watchdog");
  end

  // ---------------- scoreboard / model ----------------
  int          tests_run    = 0;
  int          tests_failed = 0;
  logic [31:0] exp_q[$];
  logic [7:0]  model_b [DEPTH*4];
  logic        exp_mis;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests_run++;
    assert (obs === exp) else begin
      tests_failed++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  function automatic int size_of(input logic [3:0] be);
    if (be == BE_BYTE) return 1;
    if (be == BE_HALF) return 2;
    return 4;
  endfunction

  function automatic bit is_mis(input logic [31:0] addr, input logic [3:0] be);
    return (int'(addr[1:0]) + size_of(be)) > 4;
  endfunction

  task automatic model_store(input logic [31:0] addr, input logic [3:0] be, input logic [31:0] data);
    int off, base;
    if (is_mis(addr, be)) begin
      exp_mis = 1'b1;
      return;
    end
    off  = int'(addr[1:0]);
    base = int'((addr >> 2) % DEPTH) * 4;
    for (int i = 0; i < size_of(be); i++) model_b[base + off + i] = data[8*i +: 8];
  endtask

  function automatic logic [31:0] model_read(input logic [31:0] addr, input logic [3:0] be);
    logic [31:0] r;
    int off, base;
    r = 32'd0;
    if (is_mis(addr, be)) return r;
    off  = int'(addr[1:0]);
    base = int'((addr >> 2) % DEPTH) * 4;
    for (int i = off; i < 4; i++) r[8*(i-off) +: 8] = model_b[base + i];
    return r;
  endfunction

  function automatic logic [31:0] model_word(input int idx);
    int b;
    b = (idx % DEPTH) * 4;
    return {model_b[b+3], model_b[b+2], model_b[b+1], model_b[b]};
  endfunction

  // ---------------- driver tasks ----------------
  task automatic apply_reset();
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    exp_mis = 1'b0;
  endtask

  task automatic do_write(input logic [31:0] addr, input logic [3:0] be, input logic [31:0] data);
    @(negedge clk);
    i_write_enable = 1'b1;
    i_write_addr   = addr;
    i_byte_enable  = be;
    i_write_data   = data;
    model_store(addr, be, data);
    @(negedge clk);
    i_write_enable = 1'b0;
  endtask

  task automatic fetch_check(input string tag, input int idx);
    @(negedge clk);
    i_read_fetch_addr = idx;
    #1;
    check(tag, o_read_fetch_data, model_word(idx));
  endtask

  // One read transaction. stall_at: cycle at which clk_en drops for 5 cycles.
  // wr_at: cycle at which a concurrent store is driven (0 = with the request,
  // in which case wr_be must equal be since the lane mask is shared).
  task automatic do_read(input string tag, input logic [31:0] addr, input logic [3:0] be,
                         input int exp_lat, input int stall_at, input int wr_at,
                         input logic [31:0] wr_addr, input logic [3:0] wr_be,
                         input logic [31:0] wr_data);
    int n;
    bit seen;
    if (wr_at >= 0) model_store(wr_addr, wr_be, wr_data);
    exp_q.push_back(model_read(addr, be));
    if (is_mis(addr, be)) exp_mis = 1'b1;
    @(negedge clk);
    i_read_req    = 1'b1;
    i_read_addr   = addr;
    i_byte_enable = be;
    if (wr_at == 0) begin
      i_write_enable = 1'b1;
      i_write_addr   = wr_addr;
      i_write_data   = wr_data;
    end
    n = 0;
    seen = 1'b0;
    while (!seen && n < 60) begin
      @(negedge clk);
      n++;
      if (o_read_ready) seen = 1'b1;
      if (n == 1) begin
        i_read_req  = 1'b0;
        i_read_addr = $urandom;
      end
      if (n == stall_at)     clk_en = 1'b0;
      if (n == stall_at + 5) clk_en = 1'b1;
      if (wr_at > 0 && n == wr_at) begin
        i_write_enable = 1'b1;
        i_write_addr   = wr_addr;
        i_byte_enable  = wr_be;
        i_write_data   = wr_data;
      end
      if (wr_at >= 0 && n == wr_at + 1) i_write_enable = 1'b0;
    end
    clk_en = 1'b1;
    i_write_enable = 1'b0;
    check({tag, "_ready_seen"}, 32'(seen), 32'd1);
    check({tag, "_data"}, o_read_data, exp_q.pop_front());
    check({tag, "_latency"}, n - 1, exp_lat);
    @(negedge clk);
    check({tag, "_ready_one_cycle"}, 32'(o_read_ready), 32'd0);
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    int n, pulses, first_n, second_n, drop_at;
    int w, sz, off, rsz, roff;
    logic [3:0] wbe, rbe;

    rst = 1'b1; clk_en = 1'b1;
    i_read_fetch_addr = 32'd0; i_read_req = 1'b0; i_read_addr = 32'd0;
    i_write_enable = 1'b0; i_byte_enable = BE_WORD; i_write_addr = 32'd0; i_write_data = 32'd0;
    exp_mis = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    check("reset_ready", 32'(o_read_ready), 32'd0);
    check("reset_data", o_read_data, 32'd0);
    check("reset_misaligned", 32'(o_misaligned), 32'd0);
    check("reset_state", 32'(o_dbg_state), 32'(ST_IDLE));

    // Give the backing array known contents.
    for (int i = 0; i < DEPTH; i++) do_write(i * 4, BE_WORD, 32'd0);
    check("clear_misaligned", 32'(o_misaligned), 32'(exp_mis));

    // Word store then read back with nominal latency.
    do_write(32'h10, BE_WORD, 32'hDEADBEEF);
    do_read("word_read", 32'h10, BE_WORD, WS + 1, -1, -1, 32'd0, 4'd0, 32'd0);
    check("word_read_value", o_read_data, 32'hDEADBEEF);

    // Byte store merges into an existing word.
    do_write(32'h10, BE_WORD, 32'h11223344);
    do_write(32'h13, BE_BYTE, 32'hFFFFFFAB);
    fetch_check("byte_merge_word", 4);
    check("byte_merge_const", o_read_fetch_data, 32'hAB223344);
    do_read("byte_read", 32'h13, BE_BYTE, WS + 1, -1, -1, 32'd0, 4'd0, 32'd0);

    // Misaligned halfword store is dropped and flagged.
    do_write(32'h20, BE_WORD, 32'h55667788);
    do_write(32'h23, BE_HALF, 32'h0000BEEF);
    check("mis_store_flag", 32'(o_misaligned), 32'(exp_mis));
    fetch_check("mis_store_unchanged", 8);
    do_read("half_read", 32'h22, BE_HALF, WS + 1, -1, -1, 32'd0, 4'd0, 32'd0);
    check("half_read_value", o_read_data, 32'h00005566);
    check("mis_sticky", 32'(o_misaligned), 32'd1);

    // Reset clears the flag but keeps the array.
    apply_reset();
    check("mis_cleared", 32'(o_misaligned), 32'd0);
    check("rst2_data", o_read_data, 32'd0);
    fetch_check("array_survives_reset", 8);

    // Combinational fetch, including index wrap.
    do_write(32'd28, BE_WORD, 32'h00500093);
    @(negedge clk);
    i_read_fetch_addr = 32'd7;
    #1 check("fetch_word7", o_read_fetch_data, 32'h00500093);
    fetch_check("fetch_wrap", DEPTH + 7);

    // Reset during WAIT abandons the read.
    @(negedge clk);
    i_read_req = 1'b1; i_read_addr = 32'h10; i_byte_enable = BE_WORD;
    @(negedge clk);
    i_read_req = 1'b0;
    check("abort_in_wait", 32'(o_dbg_state), 32'(ST_WAIT));
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("abort_state_idle", 32'(o_dbg_state), 32'(ST_IDLE));
    pulses = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (o_read_ready) pulses++;
    end
    check("abort_no_ready", pulses, 0);

    // clk_en low for 5 cycles mid-WAIT stretches latency by 5.
    do_read("stall_read", 32'h10, BE_WORD, WS + 1 + 5, 2, -1, 32'd0, 4'd0, 32'd0);

    // Store in the RESP cycle is visible; store alongside the request is serviced.
    do_read("same_cycle_store", 32'h30, BE_WORD, WS + 1, -1, WS + 1, 32'h30, BE_WORD, 32'hCAFEF00D);
    check("same_cycle_value", o_read_data, 32'hCAFEF00D);
    do_read("concurrent_store", 32'h10, BE_WORD, WS + 1, -1, 0, 32'h34, BE_WORD, 32'h0BADF00D);
    fetch_check("concurrent_store_word", 13);

    // Misaligned word read completes with zero and sets the flag.
    do_read("mis_read", 32'h11, BE_WORD, WS + 1, -1, -1, 32'd0, 4'd0, 32'd0);
    check("mis_read_flag", 32'(o_misaligned), 32'(exp_mis));
    apply_reset();

    // Request held through the ready cycle starts a second transaction.
    exp_q.push_back(model_read(32'h10, BE_WORD));
    exp_q.push_back(model_read(32'h10, BE_WORD));
    @(negedge clk);
    i_read_req = 1'b1; i_read_addr = 32'h10; i_byte_enable = BE_WORD;
    n = 0; pulses = 0; first_n = 0; second_n = 0; drop_at = -1;
    while (pulses < 2 && n < 80) begin
      @(negedge clk);
      n++;
      if (n == drop_at) i_read_req = 1'b0;
      if (o_read_ready) begin
        pulses++;
        check("held_req_data", o_read_data, exp_q.pop_front());
        if (pulses == 1) begin
          first_n = n;
          drop_at = n + 1;
        end else begin
          second_n = n;
        end
      end
    end
    i_read_req = 1'b0;
    check("held_req_pulses", pulses, 2);
    check("held_req_gap", second_n - first_n, WS + 2);
    while (exp_q.size() > 0) void'(exp_q.pop_front());
    pulses = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (o_read_ready) pulses++;
    end
    check("held_req_no_third", pulses, 0);

    // Random aligned stores and reads against the byte model.
    for (int r = 0; r < 6; r++) begin
      w    = $urandom_range(40, 63);
      sz   = $urandom_range(0, 2);
      wbe  = (sz == 0) ? BE_BYTE : (sz == 1) ? BE_HALF : BE_WORD;
      off  = (sz == 0) ? $urandom_range(0, 3) : (sz == 1) ? $urandom_range(0, 2) : 0;
      do_write(w * 4 + off, wbe, $urandom);
      rsz  = $urandom_range(0, 2);
      rbe  = (rsz == 0) ? BE_BYTE : (rsz == 1) ? BE_HALF : BE_WORD;
      roff = (rsz == 0) ? $urandom_range(0, 3) : (rsz == 1) ? $urandom_range(0, 2) : 0;
      do_read("rand_read", w * 4 + roff, rbe, WS + 1, -1, -1, 32'd0, 4'd0, 32'd0);
    end
    check("rand_no_misaligned", 32'(o_misaligned), 32'(exp_mis));

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/mem_responder.md
MEM_RESPONDER -- requirements
Module: mem_responder

Interface
REQ-001 Parameter ADDR_WIDTH, default 31, MSB index of all address ports.
REQ-002 Parameter DATA_WIDTH, default 31, MSB index of all data ports; only 31 is supported.
REQ-003 Parameter DEPTH_WORDS, default 1024, number of 32-bit words in the backing array.
REQ-004 Parameter WAIT_STATES, default 1, extra cycles inserted before each data-read response (0..15).
REQ-005 clk  in  1  sole clock; reset is synchronous and active-high.
REQ-006 rst  in  1  synchronous, active-high reset.
REQ-007 clk_en  in  1  global advance enable; no state changes when low.
REQ-008 i_read_fetch_addr  in  ADDR_WIDTH+1  instruction word index.
REQ-009 o_read_fetch_data  out  DATA_WIDTH+1  instruction word.
REQ-010 i_read_req  in  1  data-read request, held until o_read_ready.
REQ-011 i_read_addr  in  ADDR_WIDTH+1  data-read byte address.
REQ-012 o_read_data  out  DATA_WIDTH+1  right-aligned read data.
REQ-013 o_read_ready  out  1  one-cycle read-complete strobe.
REQ-014 i_write_enable  in  1  store request.
REQ-015 i_byte_enable  in  4  low-aligned lane mask (0001 byte, 0011 half, 1111 word).
REQ-016 i_write_addr  in  ADDR_WIDTH+1  store byte address.
REQ-017 i_write_data  in  DATA_WIDTH+1  low-aligned store data.
REQ-018 o_misaligned  out  1  sticky misaligned-access flag.

Function
REQ-019 Fetch port SHALL return word[i_read_fetch_addr mod DEPTH_WORDS] combinationally, with no handshake.
REQ-020 Data word index SHALL be addr[ADDR_WIDTH:2] mod DEPTH_WORDS; byte offset SHALL be addr[1:0].
REQ-021 Store: on clk_en with i_write_enable high, lanes (i_byte_enable << offset) SHALL be written with (i_write_data << 8*offset) in the same cycle.
REQ-022 Read FSM states SHALL be IDLE, WAIT, RESP.
REQ-023 IDLE->WAIT on i_read_req with WAIT_STATES>0, loading a counter with WAIT_STATES-1; IDLE->RESP on i_read_req with WAIT_STATES=0.
REQ-024 WAIT SHALL decrement the counter each clk_en cycle and go to RESP when it is 0.
REQ-025 RESP SHALL drive o_read_ready=1 for exactly one cycle, with o_read_data = word >> 8*offset (zero-filled), then return to IDLE.
REQ-026 Read address SHALL be captured at request acceptance; later address changes SHALL NOT affect the response.
REQ-027 Read data SHALL be sampled in RESP, so a store to the same word accepted in the same or an earlier cycle SHALL be visible in the result.
REQ-028 A read request still high in the cycle after RESP SHALL start a new transaction.
REQ-029 Misaligned accesses (halfword with offset 3, word with offset != 0) SHALL set o_misaligned; stores SHALL be dropped; reads SHALL complete with data 0.
REQ-030 o_misaligned SHALL clear only on reset.
REQ-031 With clk_en low, the FSM, counter, array and outputs SHALL hold.
REQ-032 Simultaneous read and write SHALL both be serviced; the FSM SHALL NOT stall stores.

Reset
REQ-033 On rst, the FSM SHALL go to IDLE, the counter to 0, o_read_ready to 0, o_read_data to 0 and o_misaligned to 0; rst SHALL override clk_en.
REQ-034 Array contents SHALL NOT be cleared by reset.
REQ-035 A read in progress when rst is asserted SHALL be abandoned with no o_read_ready pulse.

Structure
REQ-036 The FSM state enum and lane-mask constants (BE_BYTE, BE_HALF, BE_WORD) SHALL reside in shared package core_pkg.
REQ-037 Lane shift and misalignment check SHALL be a sub-module mem_lane_align, reused for the read and write paths.

Verification
REQ-038 Store word 0xDEADBEEF to byte address 0x10 with BE 1111, then read 0x10 -> o_read_data 0xDEADBEEF; o_read_ready rises WAIT_STATES+1 cycles after the request.
REQ-039 Store byte 0xAB to 0x13 with BE 0001 over word 0x11223344 -> word becomes 0xAB223344; read 0x13 -> 0x000000AB.
REQ-040 Halfword store to 0x23 -> o_misaligned=1, word unchanged, read 0x22 with BE 0011 returns the original upper half.
REQ-041 Raise rst during WAIT with WAIT_STATES=3 -> no o_read_ready pulse; FSM is IDLE on the next cycle.
REQ-042 Hold clk_en low for 5 cycles mid-WAIT -> o_read_ready is delayed by exactly 5 cycles and the data is unchanged.
REQ-043 Preload fetch word 7 = 0x00500093 -> o_read_fetch_data = 0x00500093 in the same cycle i_read_fetch_addr = 7.
